// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
//   Streams host configuration bytes, LSB first, into a configuration
//   flip-flop chain. One LOAD cycle accepts a byte. The following SHIFT
//   cycles drive it onto ccff_head with ccff_clk_en asserted.
//
//   Optional feature macro: CCFF_LOADER_READBACK_EN
//     When this macro is defined, a VERIFY phase follows the load. VERIFY
//     rotates the whole chain once (ccff_head = ccff_tail) and compares a
//     CRC-16-CCITT of the bits written against a CRC-16-CCITT of the bits
//     read back. When the macro is not defined, error is tied to 0.
//
// Parameters
//   CHAIN_LEN      number of configuration bits in the chain (1..65535)
//   CNT_W          width of the bit counter
//
// Ports
//   prog_clk       configuration clock (rising edge)
//   prog_reset_n   asynchronous active-low reset
//   start          one-cycle pulse that begins a load (IDLE/DONE only)
//   cfg_data       configuration byte from the host
//   cfg_valid      cfg_data is valid
//   cfg_ready      loader accepts a byte this cycle (LOAD only)
//   ccff_head      serial bit into the chain
//   ccff_clk_en    chain shift enable for the next prog_clk edge
//   ccff_tail      serial bit out of the chain
//   busy           load or verify in progress
//   done           last operation completed (level)
//   error          readback CRC mismatch (level)
//   bit_count      bits shifted in the current load
// ---------------------------------------------------------------------------
module ccff_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int CNT_W     = 16
) (
  input  logic             prog_clk,
  input  logic             prog_reset_n,
  input  logic             start,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             ccff_clk_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
`ifdef CCFF_LOADER_READBACK_EN
    VERIFY = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [2:0]       bidx_q, bidx_d;     // bit position within the current byte

`ifdef CCFF_LOADER_READBACK_EN
  logic [15:0]      crc_a_q, crc_a_d;   // CRC of bits written
  logic [15:0]      crc_b_q, crc_b_d;   // CRC of bits read back
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             error_q, error_d;

  // CRC-16-CCITT, poly 0x1021, MSB-first, one bit per call.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`else
  // Without readback the tail is not observed.
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= 8'h00;
      bit_count_q <= '0;
      bidx_q      <= 3'd0;
`ifdef CCFF_LOADER_READBACK_EN
      crc_a_q     <= 16'h0000;
      crc_b_q     <= 16'h0000;
      vcnt_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      bidx_q      <= bidx_d;
`ifdef CCFF_LOADER_READBACK_EN
      crc_a_q     <= crc_a_d;
      crc_b_q     <= crc_b_d;
      vcnt_q      <= vcnt_d;
      error_q     <= error_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    bidx_d      = bidx_q;
    cfg_ready   = 1'b0;
    ccff_head   = 1'b0;
    ccff_clk_en = 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
    crc_a_d     = crc_a_q;
    crc_b_d     = crc_b_q;
    vcnt_d      = vcnt_q;
    error_d     = error_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bit_count_d = '0;
          state_d     = LOAD;
`ifdef CCFF_LOADER_READBACK_EN
          error_d     = 1'b0;
          crc_a_d     = 16'hFFFF;
          crc_b_d     = 16'hFFFF;
`endif
        end
      end

      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          shreg_d = cfg_data;
          bidx_d  = 3'd0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        ccff_clk_en = 1'b1;
        ccff_head   = shreg_q[0];
        shreg_d     = {1'b0, shreg_q[7:1]};
        bit_count_d = bit_count_q + 1'b1;
        bidx_d      = bidx_q + 3'd1;
`ifdef CCFF_LOADER_READBACK_EN
        crc_a_d     = crc_step(crc_a_q, shreg_q[0]);
`endif
        // The last chain bit ends the load even mid-byte; the remaining
        // high bits of that byte are simply dropped.
        if (bit_count_q == LAST_BIT) begin
`ifdef CCFF_LOADER_READBACK_EN
          vcnt_d  = '0;
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end else if (bidx_q == 3'd7) begin
          state_d = LOAD;
        end
      end

`ifdef CCFF_LOADER_READBACK_EN
      VERIFY: begin
        // Feed the tail back into the head so that one full rotation
        // restores the loaded contents.
        ccff_clk_en = 1'b1;
        ccff_head   = ccff_tail;
        crc_b_d     = crc_step(crc_b_q, ccff_tail);
        vcnt_d      = vcnt_q + 1'b1;
        if (vcnt_q == LAST_BIT) begin
          error_d = (crc_a_q != crc_b_d);
          state_d = DONE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

`ifdef CCFF_LOADER_READBACK_EN
  assign busy  = (state_q == LOAD) || (state_q == SHIFT) || (state_q == VERIFY);
  assign error = error_q;
`else
  assign busy  = (state_q == LOAD) || (state_q == SHIFT);
  assign error = 1'b0;
`endif
  assign done      = (state_q == DONE);
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_loader
//   Directed bench for ccff_loader. A 40-bit instance and a 12-bit instance
//   each drive a shift-register model of their configuration chain.
//   The bench also builds and checks the readback variant when
//   CCFF_LOADER_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_ccff_loader;

`ifdef CCFF_LOADER_READBACK_EN
  localparam int VCYC40 = 40;
  localparam int VCYC12 = 12;
`else
  localparam int VCYC40 = 0;
  localparam int VCYC12 = 0;
`endif
  localparam logic [39:0] EXP40 = 40'h8100FF3CA5;

  logic        prog_clk = 1'b0;
  logic        prog_reset_n;
  logic        start40, start12, cfg_valid;
  logic [7:0]  cfg_data;
  logic        rdy40, head40, en40, busy40, done40, err40;
  logic        rdy12, head12, en12, busy12, done12, err12;
  logic [15:0] bc40, bc12;

  logic [39:0] chain40 = '0;
  logic [11:0] chain12 = '0;
  int          en40_cnt = 0, en12_cnt = 0, cyc = 0, flip_at = -1;
  int          n_vec = 0, n_mis = 0;
  int          t0;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(40), .CNT_W(16)) u40 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start40),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy40),
    .ccff_head(head40), .ccff_clk_en(en40), .ccff_tail(chain40[0]),
    .busy(busy40), .done(done40), .error(err40), .bit_count(bc40));

  ccff_loader #(.CHAIN_LEN(12), .CNT_W(16)) u12 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start12),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy12),
    .ccff_head(head12), .ccff_clk_en(en12), .ccff_tail(chain12[0]),
    .busy(busy12), .done(done12), .error(err12), .bit_count(bc12));

  // Chain models: head enters at the top, tail leaves from bit 0.
  // flip_at corrupts the bit about to reach the tail (readback fault).
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (en40) begin
      en40_cnt <= en40_cnt + 1;
      chain40  <= {head40, chain40[39:1]} ^ ((en40_cnt == flip_at) ? 40'h1 : 40'h0);
    end
    if (en12) begin
      en12_cnt <= en12_cnt + 1;
      chain12  <= {head12, chain12[11:1]};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel12);
    @(negedge prog_clk);
    if (sel12) start12 = 1'b1; else start40 = 1'b1;
    @(negedge prog_clk);
    start12 = 1'b0;
    start40 = 1'b0;
  endtask

  // Returns 1 ns after the edge on which the byte was accepted.
  task automatic send_byte(input bit sel12, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    cfg_data  = b;
    cfg_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (sel12 ? rdy12 : rdy40) ok = 1'b1;
      @(posedge prog_clk); #1;
    end
    cfg_valid = 1'b0;
    if (!ok) check("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_ready40();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (rdy40) ok = 1'b1;
      else begin @(posedge prog_clk); #1; end
    end
    if (!ok) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input bit sel12);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      if (sel12 ? done12 : done40) ok = 1'b1;
      else begin @(posedge prog_clk); #1; end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  // Loads A5,3C,FF,00,81 into the 40-bit instance; gap = stall cycles
  // inserted between bytes; heads = check the first byte's bit stream.
  task automatic load40(input int gap, input bit heads);
    logic [7:0] bytes [5];
    logic [7:0] b;
    logic [15:0] snap;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    pulse_start(1'b0);
    check("start_clears_done", {63'd0, done40}, 64'd0);
    check("start_clears_count", {48'd0, bc40}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (gap > 0 && i > 0) begin
        wait_ready40();
        snap = bc40;
        for (int g = 0; g < gap; g++) begin
          check("stall_ready", {63'd0, rdy40}, 64'd1);
          check("stall_en", {63'd0, en40}, 64'd0);
          check("stall_count", {48'd0, bc40}, {48'd0, snap});
          @(posedge prog_clk); #1;
        end
      end
      send_byte(1'b0, bytes[i]);
      if (i == 0) begin
        t0 = cyc;
        if (heads) begin
          b = bytes[0];
          for (int k = 0; k < 8; k++) begin
            check("head_bit", {62'd0, en40, head40}, {62'd0, 1'b1, b[k]});
            if (k < 7) begin @(posedge prog_clk); #1; end
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    prog_reset_n = 1'b0;
    start40 = 1'b0; start12 = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    repeat (2) @(negedge prog_clk);
    check("reset_outs40", {58'd0, rdy40, head40, en40, busy40, done40, err40}, 64'd0);
    check("reset_cnt40", {48'd0, bc40}, 64'd0);
    check("reset_outs12", {58'd0, rdy12, head12, en12, busy12, done12, err12}, 64'd0);
    prog_reset_n = 1'b1;

    // Back-to-back load: the final shift cycle is the 45th counted from
    // the transfer cycle, so done rises 44 edges after the first transfer.
    base = en40_cnt;
    load40(0, 1'b1);
    wait_done(1'b0);
    check("done_latency", 64'(cyc - t0), 64'(44 + VCYC40));
    check("done40", {63'd0, done40}, 64'd1);
    check("busy40_idle", {63'd0, busy40}, 64'd0);
    check("bit_count40", {48'd0, bc40}, 64'd40);
    check("en_cycles40", 64'(en40_cnt - base), 64'(40 + VCYC40));
    check("chain40", {24'd0, chain40}, {24'd0, EXP40});
    check("error40", {63'd0, err40}, 64'd0);

    // Host stalls between bytes give the same chain contents.
    chain40 = '0;
    base = en40_cnt;
    load40(3, 1'b0);
    wait_done(1'b0);
    check("stall_chain40", {24'd0, chain40}, {24'd0, EXP40});
    check("stall_en_cycles40", 64'(en40_cnt - base), 64'(40 + VCYC40));
    check("stall_count40", {48'd0, bc40}, 64'd40);

    // Reset mid-shift: outputs drop immediately, then a fresh load works.
    pulse_start(1'b0);
    send_byte(1'b0, 8'hA5);
    @(posedge prog_clk); #2;
    prog_reset_n = 1'b0;
    #1;
    check("midreset_outs", {58'd0, rdy40, head40, en40, busy40, done40, err40}, 64'd0);
    check("midreset_cnt", {48'd0, bc40}, 64'd0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    chain40 = '0;
    load40(0, 1'b0);
    wait_done(1'b0);
    check("post_reset_chain", {24'd0, chain40}, {24'd0, EXP40});
    check("post_reset_done", {48'd0, done40, bc40[14:0]}, {48'd0, 1'b1, 15'd40});

    // Short chain: upper nibble of the last byte is dropped; a start
    // pulse during SHIFT must not restart the load.
    base = en12_cnt;
    pulse_start(1'b1);
    send_byte(1'b1, 8'hFF);
    start12 = 1'b1;
    @(posedge prog_clk); #1;
    start12 = 1'b0;
    check("ignored_start_cnt", {48'd0, bc12}, 64'd1);
    check("ignored_start_busy", {63'd0, busy12}, 64'd1);
    send_byte(1'b1, 8'h0F);
    wait_done(1'b1);
    check("en_cycles12", 64'(en12_cnt - base), 64'(12 + VCYC12));
    check("chain12", {52'd0, chain12}, 64'hFFF);
    check("bit_count12", {48'd0, bc12}, 64'd12);
    check("done12", {62'd0, done12, err12}, 64'd2);

`ifdef CCFF_LOADER_READBACK_EN
    // Corrupt one bit ten cycles into VERIFY, before it reaches the tail.
    flip_at = en40_cnt + 50;
    load40(0, 1'b0);
    wait_done(1'b0);
    flip_at = -1;
    check("flip_error", {63'd0, err40}, 64'd1);
    check("flip_done", {63'd0, done40}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
